// File: rtl/mesh_pkg.sv
// mesh_pkg: shared mesh geometry, scan FSM states and toroidal neighbour index helpers
package mesh_pkg;
    localparam int COLS   = 26;
    localparam int ROWS   = 18;
    localparam int NODES  = COLS * ROWS;
    localparam int NODE_W = 4;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    function automatic int north(input int i);
        return (i - COLS + NODES) % NODES;
    endfunction

    function automatic int south(input int i);
        return (i + COLS) % NODES;
    endfunction

    function automatic int east(input int i);
        return (i / COLS) * COLS + (i % COLS + 1) % COLS;
    endfunction

    function automatic int west(input int i);
        return (i / COLS) * COLS + (i % COLS + COLS - 1) % COLS;
    endfunction
endpackage

// File: rtl/contour_row_eval.sv
// contour_row_eval: one torus row of the contour rule plus its cleared-node count
module contour_row_eval
    import mesh_pkg::*;
(
    input  logic [COLS-1:0] up,
    input  logic [COLS-1:0] mid,
    input  logic [COLS-1:0] dn,
    output logic [COLS-1:0] row,
    output logic [4:0]      zeros
);
    always_comb begin
        row = mid;
        for (int c = 0; c < COLS; c++)
            row[c] = mid[c] | ~(up[c] | dn[c] | mid[(c + 1) % COLS] | mid[(c + COLS - 1) % COLS]);
    end

    always_comb begin
        zeros = '0;
        for (int c = 0; c < COLS; c++)
            zeros = zeros + {4'd0, ~row[c]};
    end
endmodule

// File: rtl/mesh_contour_scan.sv
// mesh_contour_scan: captures a mesh frame's saturation map and scans it row by row into a contour map
module mesh_contour_scan
    import mesh_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mesh_valid,
    input  logic [COLS*ROWS*NODE_W-1:0]   mesh_in,
    output logic                          mesh_ready,
    output logic [NODES-1:0]              contour_out,
    output logic [8:0]                    edge_count,
    output logic                          contour_valid,
    input  logic                          contour_ready
);
    state_t           state_q, state_d;
    logic [4:0]       row_q, row_d, up_r, dn_r;
    logic [NODES-1:0] sat_q, sat_d, map_q, map_d, sat_in;
    logic [8:0]       cnt_q, cnt_d;
    logic [COLS-1:0]  row_c;
    logic [4:0]       zeros;

    always_comb begin
        sat_in = '0;
        for (int i = 0; i < NODES; i++)
            sat_in[i] = &mesh_in[i*NODE_W +: NODE_W];
    end

    assign up_r = (row_q == 5'd0) ? 5'(ROWS - 1) : row_q - 5'd1;
    assign dn_r = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

    contour_row_eval u_eval (
        .up    (sat_q[up_r*COLS +: COLS]),
        .mid   (sat_q[row_q*COLS +: COLS]),
        .dn    (sat_q[dn_r*COLS +: COLS]),
        .row   (row_c),
        .zeros (zeros)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        sat_d   = sat_q;
        map_d   = map_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (mesh_valid) begin
                sat_d   = sat_in;
                map_d   = '1;
                cnt_d   = '0;
                row_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                map_d[row_q*COLS +: COLS] = row_c;
                cnt_d   = cnt_q + {4'd0, zeros};
                row_d   = row_q + 5'd1;
                state_d = (row_q == 5'(ROWS - 1)) ? DONE : SCAN;
            end
            DONE: state_d = contour_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            sat_q   <= '0;
            map_q   <= '1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            sat_q   <= sat_d;
            map_q   <= map_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mesh_ready    = (state_q == IDLE);
    assign contour_valid = (state_q == DONE);
    assign contour_out   = map_q;
    assign edge_count    = cnt_q;
endmodule

// File: tb/tb_mesh_contour_scan.sv
// tb_mesh_contour_scan: randomized scoreboard bench against a per-node torus contour model
module tb_mesh_contour_scan;
    localparam int C = 26, R = 18, N = 468, FW = 1872;

    logic          clk = 0, rst, mesh_valid, contour_ready, mesh_ready, contour_valid;
    logic [FW-1:0] mesh_in;
    logic [N-1:0]  contour_out;
    logic [8:0]    edge_count;

    typedef struct {
        logic [N-1:0] map;
        int           cnt;
        int           acc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0, checks = 0, failures = 0, last_xfer = -1, last_acc = -1;

    mesh_contour_scan dut (
        .clk(clk), .rst(rst), .mesh_valid(mesh_valid), .mesh_in(mesh_in),
        .mesh_ready(mesh_ready), .contour_out(contour_out), .edge_count(edge_count),
        .contour_valid(contour_valid), .contour_ready(contour_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [FW-1:0] f, input int acc);
        exp_t e;
        bit   s[N];
        for (int i = 0; i < N; i++) s[i] = (f[i*4 +: 4] == 4'hF);
        e.map = '1;
        e.cnt = 0;
        e.acc = acc;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                bit nb;
                nb = s[((r + R - 1) % R) * C + c] || s[((r + 1) % R) * C + c] ||
                     s[r * C + (c + 1) % C] || s[r * C + (c + C - 1) % C];
                if (!s[r * C + c] && nb) begin
                    e.map[r * C + c] = 1'b0;
                    e.cnt++;
                end
            end
        return e;
    endfunction

    function automatic logic [FW-1:0] rand_frame(input int one_in);
        logic [FW-1:0] f;
        for (int i = 0; i < N; i++)
            f[i*4 +: 4] = ($urandom_range(0, one_in - 1) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        return f;
    endfunction

    function automatic logic [FW-1:0] checker_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < N; i++)
            f[i*4 +: 4] = (((i / C) + (i % C)) % 2 == 0) ? 4'hF : 4'($urandom_range(0, 14));
        return f;
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input logic [FW-1:0] f);
        mesh_in    = f;
        mesh_valid = 1;
        for (int k = 0; k < 100 && !mesh_ready; k++) @(negedge clk);
        if (!mesh_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=busy required=ready");
            mesh_valid = 0;
            return;
        end
        last_acc = cyc + 1;
        sbq.push_back(model(f, last_acc));
        @(negedge clk);
        mesh_valid = 0;
        mesh_in    = rand_frame(2);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sbq.size() > 0; k++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sbq.size());
        end
    endtask

    // Monitor samples 2 time units after the falling edge, after the driver's updates settle
    initial begin
        logic         prev_v = 0;
        logic [N-1:0] prev_map;
        logic [8:0]   prev_cnt;
        exp_t         e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) prev_v = 0;
            else begin
                if (contour_valid && !prev_v) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_valid actual=1 required=0");
                    end else if (cyc - sbq[0].acc != 18) begin
                        failures++;
                        $display("FAIL latency actual=%0d required=18 edges", cyc - sbq[0].acc);
                    end
                end
                if (contour_valid && prev_v) begin
                    check("hold_map", contour_out, prev_map);
                    check("hold_cnt", N'(edge_count), N'(prev_cnt));
                end
                if (contour_valid && contour_ready && sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check("contour_out", contour_out, e.map);
                    check("edge_count", N'(edge_count), N'(e.cnt));
                    last_xfer = cyc + 1;
                end
                prev_v   = contour_valid;
                prev_map = contour_out;
                prev_cnt = edge_count;
            end
        end
    end

    initial begin
        logic [FW-1:0] f;
        int a;
        rst           = 1;
        mesh_valid    = 0;
        contour_ready = 1;
        mesh_in       = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", N'(mesh_ready), N'(1));
        check("rst_valid", N'(contour_valid), N'(0));
        check("rst_map", contour_out, '1);
        check("rst_cnt", N'(edge_count), N'(0));
        rst = 0;
        @(negedge clk);

        send('0);
        send('1);
        f = '0;
        f[3:0] = 4'hF;
        send(f);
        send(checker_frame());
        drain();

        // Hold DONE with a new frame pending and mesh_in churning
        contour_ready = 0;
        send(rand_frame(3));
        mesh_valid = 1;
        for (int k = 0; k < 100 && !contour_valid; k++) begin
            @(negedge clk);
            mesh_in = rand_frame(2);
        end
        repeat (10) begin
            @(negedge clk);
            mesh_in = rand_frame(2);
            check("hold_ready", N'(mesh_ready), N'(0));
        end
        contour_ready = 1;
        send(rand_frame(4));
        check("accept_after_xfer", N'(last_acc), N'(last_xfer + 1));

        // Reset while row 9 is being scanned
        send(rand_frame(3));
        repeat (9) @(negedge clk);
        rst = 1;
        sbq.delete();
        @(negedge clk);
        rst = 0;
        check("abort_valid", N'(contour_valid), N'(0));
        check("abort_cnt", N'(edge_count), N'(0));
        check("abort_ready", N'(mesh_ready), N'(1));
        check("abort_map", contour_out, '1);
        send('0);

        // Back-to-back random frames with contour_ready high
        for (int t = 0; t < 6; t++) begin
            a = last_acc;
            send(rand_frame(2 + t));
            check("frame_period", N'(last_acc - a), N'(20));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
